evt_stream_fifo: RTL and testbench
==================================

Name: evt_stream_fifo

Overview:
- Parametrised first-word-fall-through FIFO for EVT 2.0 words, sitting between the sensor interface and the EVT decoder.
- Uses a valid/ready handshake on both sides and stores words in inferred iCE40 block RAM (simple dual-port).
- Adds almost-full/almost-empty flags, synchronous flush, and a saturating counter of words dropped on overflow.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- DEPTH, 512, RAM entries; must be a power of 2, minimum 4.
- PTR_BITS, $clog2(DEPTH), RAM address width.
- AFULL_THRESH, DEPTH-16, almost_full asserts when level >= this value.
- AEMPTY_THRESH, 4, almost_empty asserts when level <= this value.
- DROP_W, 16, width of the drop counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_WIDTH  upstream word.
- in_ready  out  1  FIFO can accept a word this cycle.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  DATA_WIDTH  head word, first-word-fall-through.
- out_ready  in  1  downstream consumes the head word.
- level  out  PTR_BITS+2  words held (RAM plus output register).
- almost_full  out  1  level >= AFULL_THRESH.
- almost_empty  out  1  level <= AEMPTY_THRESH.
- drop_count  out  DROP_W  saturating count of rejected words.
- drop_clr  in  1  synchronous clear of drop_count.
- high_water  out  PTR_BITS+2  peak level; see Optional Feature.

Behaviour:
Reset (rst_n low, asynchronous):
- Pointers = 0, out_valid = 0, out_data = 0, drop_count = 0, high_water = 0.
- Hence in_ready = 1, level = 0, almost_empty = 1, almost_full = 0.

Storage and pointers:
- wr_ptr and rd_ptr are PTR_BITS+1 bits wide; the MSB is a wrap bit.
- mem_count = wr_ptr - rd_ptr (modulo arithmetic), range 0..DEPTH.
- in_ready = (mem_count != DEPTH); it is registered-pointer based and has no combinational path from out_ready.

Write:
- Occurs when in_valid && in_ready: mem[wr_ptr] <= in_data, wr_ptr increments.

Drop:
- Occurs when in_valid && !in_ready; the word is discarded.
- drop_count increments and saturates at 2^DROP_W-1.
- drop_clr has priority over a simultaneous drop, so the count becomes 0.

Output stage:
- The RAM read-data register is the output register.
- pop = out_valid && out_ready.
- load = (mem_count != 0) && (!out_valid || out_ready). On load, out_data <= mem[rd_ptr], rd_ptr increments, and out_valid <= 1.
- Otherwise, if pop, out_valid <= 0. Otherwise out_valid holds, and out_data is held whenever there is no load.

Latency and throughput:
- A word accepted on edge k, into an empty FIFO, is presented on out_data after edge k+1.
- With in_valid and out_ready held high, throughput is sustained at 1 word per cycle.

Level and flags:
- level = mem_count + out_valid, maximum DEPTH+1.
- almost_full and almost_empty are combinational from level.

Simultaneous events:
- Write and load in the same cycle are independent. Reads only address entries whose write has already been committed, so there is no read-during-write hazard.
- A write while full, in the same cycle as a load, is still dropped, because in_ready was 0.

Flush:
- Pointers = 0, out_valid = 0; drop_count is kept.
- A write in the flush cycle is discarded and not counted as a drop.

Reset mid-operation:
- All state returns to reset values immediately; any in-flight word is lost.

Optional Feature:
FIFO_HIGHWATER_EN
- Defined: high_water register <= max(high_water, level) every cycle. It is cleared by reset, by flush, and by drop_clr.
- Undefined: high_water is tied to 0 and no comparator or register is built.

Decomposition:
- Package evt_fifo_pkg holds:
  - EVT_WORD_W = 32
  - typedef evt_word_t (logic [EVT_WORD_W-1:0])
  - function clog2_min1 for pointer sizing.
- One sub-module: evt_fifo_bram_sdp, a simple dual-port RAM with a registered read and read-enable. This isolates BRAM inference.
- Control, pointer logic, flags and counters stay in evt_stream_fifo.

Test Plan (DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=1 unless stated):
1. Reset, then write 0xA5A5_0001 at edge k with out_ready=0 -> out_valid=1 and out_data=0xA5A5_0001 after edge k+1; level=1; almost_empty=1.
2. Write 9 words 1..9 with out_ready=0 -> all 9 accepted, in_ready=0 after the 9th, level=9, almost_full=1 from level 6. A 10th write gives drop_count=1. Draining returns 1..9 in order.
3. in_valid=out_ready=1 for 100 cycles with an incrementing pattern -> after the initial 1-cycle bubble there is one pop per cycle, no gaps, data in order, level stays at or below 2.
4. drop_count at 0xFFFE, then 3 overflow attempts -> drop_count=0xFFFF. drop_clr asserted together with a drop -> 0.
5. Half-full FIFO, flush asserted together with in_valid -> next cycle level=0, out_valid=0, drop_count unchanged. With FIFO_HIGHWATER_EN, high_water=0.
6. rst_n pulsed low asynchronously mid-burst (between edges) -> outputs reach reset values before the next edge. Operation resumes cleanly after rst_n rises.

Source files
------------

// File: rtl/evt_fifo_pkg.sv
// Shared types and sizing helpers for the EVT 2.0 stream FIFO.
package evt_fifo_pkg;

   localparam int EVT_WORD_W = 32;

   typedef logic [EVT_WORD_W-1:0] evt_word_t;

   // Address width for n entries, never less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(n)) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/evt_fifo_bram_sdp.sv
// Simple dual-port RAM with registered, enabled read; shaped for iCE40 block RAM inference.
module evt_fifo_bram_sdp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_W     = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_W)-1];

   // NOTE: the array has no reset; resetting it would stop block RAM inference,
   // and the pointers already guarantee no stale entry is ever read.
   // NOTE: sequential state uses non-blocking assignments so every reader sees
   // the pre-edge value regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // The read register doubles as the FIFO output register, so it is cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/evt_stream_fifo.sv
// First-word-fall-through EVT word FIFO with flags, flush and drop counter.
// Optional peak-level tracking is built when FIFO_HIGHWATER_EN is defined.
module evt_stream_fifo
   import evt_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = EVT_WORD_W,
   parameter int DEPTH         = 512,
   parameter int PTR_BITS      = clog2_min1(DEPTH),
   parameter int AFULL_THRESH  = DEPTH - 16,
   parameter int AEMPTY_THRESH = 4,
   parameter int DROP_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [PTR_BITS+1:0]   level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [DROP_W-1:0]     drop_count,
   input  logic                  drop_clr,
   output logic [PTR_BITS+1:0]   high_water
);

   localparam int LVL_W = PTR_BITS + 2;
   localparam logic [PTR_BITS:0]   DEPTH_P  = (PTR_BITS+1)'(DEPTH);
   localparam logic [LVL_W-1:0]    AFULL_L  = LVL_W'(AFULL_THRESH);
   localparam logic [LVL_W-1:0]    AEMPTY_L = LVL_W'(AEMPTY_THRESH);
   localparam logic [DROP_W-1:0]   DROP_MAX = '1;

   logic [PTR_BITS:0] wr_ptr;
   logic [PTR_BITS:0] rd_ptr;
   logic [PTR_BITS:0] mem_count;
   logic              wr_en;
   logic              drop;
   logic              pop;
   logic              load;
   logic              out_valid_nxt;

   // Wrap bit in the MSB lets full (DEPTH) and empty (0) be told apart.
   assign mem_count = wr_ptr - rd_ptr;
   assign in_ready  = (mem_count != DEPTH_P);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      wr_en         = 1'b0;
      drop          = 1'b0;
      pop           = out_valid && out_ready;
      load          = 1'b0;
      out_valid_nxt = out_valid;
      if (!flush) begin
         wr_en = in_valid && in_ready;
         drop  = in_valid && !in_ready;
         load  = (mem_count != '0) && (!out_valid || out_ready);
      end
      if (flush) begin
         out_valid_nxt = 1'b0;
      end else if (load) begin
         out_valid_nxt = 1'b1;
      end else if (pop) begin
         out_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid_nxt;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (load)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= '0;
      end else if (drop_clr) begin
         drop_count <= '0;
      end else if (drop && (drop_count != DROP_MAX)) begin
         drop_count <= drop_count + 1'b1;
      end
   end

   // Reads only ever target entries committed on an earlier edge.
   evt_fifo_bram_sdp #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (PTR_BITS)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .waddr (wr_ptr[PTR_BITS-1:0]),
      .wdata (in_data),
      .re    (load),
      .raddr (rd_ptr[PTR_BITS-1:0]),
      .rdata (out_data)
   );

   assign level        = {1'b0, mem_count} + LVL_W'(out_valid);
   assign almost_full  = (level >= AFULL_L);
   assign almost_empty = (level <= AEMPTY_L);

`ifdef FIFO_HIGHWATER_EN
   logic [LVL_W-1:0] high_water_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_water_q <= '0;
      end else if (flush || drop_clr) begin
         high_water_q <= '0;
      end else if (level > high_water_q) begin
         high_water_q <= level;
      end
   end

   assign high_water = high_water_q;
`else
   assign high_water = '0;
`endif

endmodule

// File: tb/tb_evt_stream_fifo.sv
// Self-checking bench for evt_stream_fifo: queue-based reference model plus directed checks.
module tb_evt_stream_fifo;

   localparam int DW     = 32;
   localparam int DEPTH  = 8;
   localparam int PB     = 3;
   localparam int AFULL  = 6;
   localparam int AEMPTY = 1;
   localparam int DROPW  = 16;
   localparam int DMAX   = 65535;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic [DW-1:0]   in_data;
   logic            in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_ready;
   logic [PB+1:0]   level;
   logic            almost_full;
   logic            almost_empty;
   logic [DROPW-1:0] drop_count;
   logic            drop_clr;
   logic [PB+1:0]   high_water;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   evt_stream_fifo #(
      .DATA_WIDTH    (DW),
      .DEPTH         (DEPTH),
      .AFULL_THRESH  (AFULL),
      .AEMPTY_THRESH (AEMPTY),
      .DROP_W        (DROPW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .drop_count   (drop_count),
      .drop_clr     (drop_clr),
      .high_water   (high_water)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model: q holds every word in the FIFO, head first; ov_m says the head is presented.
   logic [DW-1:0] q[$];
   bit            ov_m;
   int            dc_m;
   int            hw_m;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         ov_m = 1'b0;
         dc_m = 0;
         hw_m = 0;
      end else begin
         int held;
         int stored;
         bit room;
         held   = q.size();
         stored = held - int'(ov_m);
         room   = (stored != DEPTH);
         if (flush || drop_clr) hw_m = 0;
         else if (held > hw_m) hw_m = held;
         if (drop_clr) dc_m = 0;
         else if (in_valid && !room && !flush && dc_m != DMAX) dc_m++;
         if (flush) begin
            q.delete();
            ov_m = 1'b0;
         end else begin
            if (ov_m && out_ready) void'(q.pop_front());
            ov_m = (stored > 0) || (ov_m && !out_ready);
            if (in_valid && room) q.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         int held;
         held = q.size();
         check("in_ready", in_ready, (held - int'(ov_m)) != DEPTH);
         check("level", level, held);
         check("out_valid", out_valid, ov_m);
         if (ov_m) check("out_data", out_data, q[0]);
         check("almost_full", almost_full, held >= AFULL);
         check("almost_empty", almost_empty, held <= AEMPTY);
         check("drop_count", drop_count, dc_m);
`ifdef FIFO_HIGHWATER_EN
         check("high_water", high_water, hw_m);
`else
         check("high_water", high_water, 0);
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within the time bound");
      $fatal(1, "timeout");
   end

   task automatic reset_values(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_level"}, level, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_almost_empty"}, almost_empty, 1);
      check({tag, "_almost_full"}, almost_full, 0);
      check({tag, "_drop_count"}, drop_count, 0);
      check({tag, "_high_water"}, high_water, 0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; drop_clr = 1'b0;
      repeat (3) @(negedge clk);
      reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single word, one-cycle fall-through latency
      in_valid = 1'b1; in_data = 32'hA5A5_0001;
      @(negedge clk);
      in_valid = 1'b0;
      check("t1_not_yet_valid", out_valid, 0);
      check("t1_level_k", level, 1);
      @(negedge clk);
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 32'hA5A5_0001);
      check("t1_level", level, 1);
      check("t1_aempty", almost_empty, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t1_drained", level, 0);

      // 2: fill to DEPTH+1, overflow once, drain in order
      for (int i = 1; i <= 9; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         @(negedge clk);
         check("t2_level", level, i);
         check("t2_afull", almost_full, i >= 6);
      end
      check("t2_in_ready", in_ready, 0);
      in_data = 32'd10;
      @(negedge clk);
      in_valid = 1'b0;
      check("t2_drop", drop_count, 1);
      check("t2_level_full", level, 9);
      out_ready = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         check("t2_drain_valid", out_valid, 1);
         check("t2_drain_data", out_data, i);
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("t2_empty", out_valid, 0);

      // 3: streaming at one word per cycle after a one-cycle bubble
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1; out_ready = 1'b1; in_data = 32'd1000 + DW'(i);
         @(negedge clk);
         check("t3_level_max", level <= 2, 1);
         if (i == 0) begin
            check("t3_bubble", out_valid, 0);
         end else begin
            check("t3_valid", out_valid, 1);
            check("t3_data", out_data, 32'd1000 + DW'(i - 1));
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_last", out_data, 32'd1099);
      @(negedge clk);
      out_ready = 1'b0;
      check("t3_empty", level, 0);

      // 4: drop counter saturation and clear priority
      drop_clr = 1'b1;
      @(negedge clk);
      drop_clr = 1'b0;
      check("t4_clr", drop_count, 0);
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_data = 32'd200 + DW'(i);
         @(negedge clk);
      end
      repeat (65534) @(negedge clk);
      check("t4_fffe", drop_count, 16'hFFFE);
      repeat (3) @(negedge clk);
      check("t4_sat", drop_count, 16'hFFFF);
      drop_clr = 1'b1;
      @(negedge clk);
      drop_clr = 1'b0;
      check("t4_clr_prio", drop_count, 0);
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      check("t4_two_drops", drop_count, 2);

      // 5: flush a partly drained FIFO with a concurrent write
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      out_ready = 1'b0;
      check("t5_half", level, 4);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("t5_level", level, 0);
      check("t5_valid", out_valid, 0);
      check("t5_drops_kept", drop_count, 2);
      check("t5_in_ready", in_ready, 1);
`ifdef FIFO_HIGHWATER_EN
      check("t5_high_water", high_water, 0);
`endif
      @(negedge clk);
      check("t5_still_empty", level, 0);

      // 6: asynchronous reset mid-burst
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 32'd300 + DW'(i);
         @(negedge clk);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      reset_values("async_rst");
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h0000_0077;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("t6_resume_valid", out_valid, 1);
      check("t6_resume_data", out_data, 32'h0000_0077);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t6_resume_empty", level, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
